lsu_ctrl: RTL and testbench

//  Load/store sequencer between the execute stage and the data memory. Accepts one

---
 rtl/lsu_if.sv | 41 ++++
 rtl/lsu_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if: request, response and data-memory signals of the load/store sequencer.
//   req_*  : execute stage -> LSU request handshake (valid/ready)
//   resp_* : LSU -> consumer response handshake (valid/ready)
//   mem_*  : LSU <-> data memory (strobes, address, MemOp, data)
// Modports:
//   slave  : the LSU side (lsu_ctrl)
//   master : the environment side (execute stage, consumer and data memory)
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [2:0]  req_op;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic [2:0]  mem_op;
    logic [31:0] mem_wdata;
    logic        mem_rd_stb;
    logic        mem_wr_stb;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wr, req_op, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_op, mem_wdata, mem_rd_stb, mem_wr_stb
    );

    modport master (
        output req_valid, req_addr, req_wr, req_op, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_op, mem_wdata, mem_rd_stb, mem_wr_stb
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and the data memory.
// Takes one request at a time, rejects misaligned/illegal accesses without
// touching memory, otherwise issues a single one-cycle read or write strobe,
// waits RD_LATENCY cycles for load data and returns a response held until
// the consumer accepts it.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : lsu_if.slave (request, response and data-memory signals)
//   busy   : high whenever the sequencer is not idle
// Parameters:
//   RD_LATENCY : cycles from the read-strobe cycle to valid mem_rdata (1..15)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request, req_ready high
// WR_ISSUE | mem_wr_stb high for this single cycle
// RD_ISSUE | mem_rd_stb high for this single cycle, latency counter loads
// RD_WAIT  | counting down the read latency, captures mem_rdata at count 1
// RESP     | resp_valid high, result held until resp_ready
//
// All outputs are registered, so req_ready is low in the very first cycle
// after reset and rises one cycle later; between transactions it rises on
// the same edge that completes the response handshake.
module lsu_ctrl #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus,
    output logic  busy
);
    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic [31:0]        mem_addr_q;
    logic [2:0]         mem_op_q;
    logic [31:0]        mem_wdata_q;
    logic               mem_rd_stb_q;
    logic               mem_wr_stb_q;
    logic               busy_q;
    logic               req_err_d;

    // Illegal MemOp encodings, stores of unsigned-load ops, and alignment.
    // A halfword only crosses a word boundary at offset 3.
    always_comb begin
        req_err_d = 1'b1;
        case (bus.req_op)
            3'b000:  req_err_d = 1'b0;
            3'b001:  req_err_d = (bus.req_addr[1:0] == 2'b11);
            3'b010:  req_err_d = (bus.req_addr[1:0] != 2'b00);
            3'b100:  req_err_d = bus.req_wr;
            3'b101:  req_err_d = bus.req_wr || (bus.req_addr[1:0] == 2'b11);
            default: req_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_op_q     <= '0;
            mem_wdata_q  <= '0;
            mem_rd_stb_q <= 1'b0;
            mem_wr_stb_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses by construction.
            mem_rd_stb_q <= 1'b0;
            mem_wr_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        mem_addr_q  <= bus.req_addr;
                        mem_op_q    <= bus.req_op;
                        mem_wdata_q <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_err_d) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= RESP;
                        end else if (bus.req_wr) begin
                            mem_wr_stb_q <= 1'b1;
                            state_q      <= WR_ISSUE;
                        end else begin
                            mem_rd_stb_q <= 1'b1;
                            state_q      <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= RESP;
                end
                RD_ISSUE: begin
                    cnt_q   <= CNT_W'(RD_LATENCY);
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= bus.mem_rdata;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    req_ready_q  <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_op     = mem_op_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_rd_stb = mem_rd_stb_q;
    assign bus.mem_wr_stb = mem_wr_stb_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: two instances (RD_LATENCY 1 and 3) share clock and
// reset. Stimulus pushes hand-computed expected responses into a per-lane
// queue; a per-lane monitor checks strobes and responses against the front.
module tb_lsu_ctrl;
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nstb;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] wdata;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   nchk;
    int   nfail;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic        req_wr     [2];
    logic [2:0]  req_op     [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic [31:0] mem_addr   [2];
    logic [2:0]  mem_op     [2];
    logic [31:0] mem_wdata  [2];
    logic        mem_rd_stb [2];
    logic        mem_wr_stb [2];
    logic [31:0] mem_val    [2];
    logic        busy       [2];

    exp_t exp_q [2][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        nchk++;
        nfail++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : 3;
        lsu_if bus ();
        logic [3:0] pipe;
        int seen;
        int nstb;
        int acc_cyc;

        assign bus.req_valid  = req_valid[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wr     = req_wr[g];
        assign bus.req_op     = req_op[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.resp_ready = resp_ready[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign resp_err[g]    = bus.resp_err;
        assign mem_addr[g]    = bus.mem_addr;
        assign mem_op[g]      = bus.mem_op;
        assign mem_wdata[g]   = bus.mem_wdata;
        assign mem_rd_stb[g]  = bus.mem_rd_stb;
        assign mem_wr_stb[g]  = bus.mem_wr_stb;

        // Memory returns data only in the cycle exactly LAT after the strobe.
        assign bus.mem_rdata = pipe[LAT-1] ? mem_val[g] : 32'hBAD0_BAD0;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe <= '0;
            else        pipe <= {pipe[2:0], bus.mem_rd_stb};
        end

        lsu_ctrl #(.RD_LATENCY(LAT)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus),
            .busy  (busy[g])
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                seen = 0;
                nstb = 0;
            end else begin
                if (mem_rd_stb[g] || mem_wr_stb[g]) begin
                    nstb++;
                    chk("single_strobe", 32'(mem_rd_stb[g] & mem_wr_stb[g]), 32'd0);
                    if (exp_q[g].size() == 0) begin
                        timeout_fail("unexpected_strobe");
                    end else begin
                        chk("strobe_kind", 32'(mem_wr_stb[g]), 32'(exp_q[g][0].wr));
                        chk("mem_addr", mem_addr[g], exp_q[g][0].addr);
                        chk("mem_op", 32'(mem_op[g]), 32'(exp_q[g][0].op));
                        if (mem_wr_stb[g]) chk("mem_wdata", mem_wdata[g], exp_q[g][0].wdata);
                    end
                end
                if (req_valid[g] && req_ready[g]) acc_cyc = cyc;
                if (resp_valid[g]) begin
                    if (exp_q[g].size() == 0) begin
                        timeout_fail("unexpected_resp");
                    end else begin
                        if (seen == 0) begin
                            seen = 1;
                            chk("resp_latency", 32'(cyc - acc_cyc), 32'(exp_q[g][0].lat));
                        end
                        chk("resp_rdata", resp_rdata[g], exp_q[g][0].rdata);
                        chk("resp_err", 32'(resp_err[g]), 32'(exp_q[g][0].err));
                        chk("req_ready_in_resp", 32'(req_ready[g]), 32'd0);
                        if (resp_ready[g]) begin
                            chk("strobe_count", 32'(nstb), 32'(exp_q[g][0].nstb));
                            void'(exp_q[g].pop_front());
                            seen = 0;
                            nstb = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input logic [31:0] a, input logic w, input logic [2:0] op,
                         input logic [31:0] wd, input logic [31:0] mv,
                         input logic e, input logic [31:0] rd, input int lat);
        exp_t x;
        bit ok;
        x.err = e; x.rdata = rd; x.lat = lat; x.nstb = e ? 0 : 1;
        x.wr = w; x.addr = a; x.op = op; x.wdata = wd;
        @(posedge clk); #1;
        exp_q[d].push_back(x);
        mem_val[d]   = mv;
        req_addr[d]  = a;
        req_wr[d]    = w;
        req_op[d]    = op;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("req_accept");
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 60; i++) begin
            if (exp_q[d].size() == 0) break;
            @(negedge clk);
        end
        if (exp_q[d].size() != 0) begin
            timeout_fail("resp_wait");
            exp_q[d].delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        nchk = 0;
        nfail = 0;
        cyc = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = '0; req_wr[d] = 1'b0;
            req_op[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b1; mem_val[d] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_strobes", 32'({mem_rd_stb[d], mem_wr_stb[d]}), 32'd0);
            chk("rst_mem_addr", mem_addr[d], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_req_ready", 32'(req_ready[0]), 32'd1);

        // Lane 0: RD_LATENCY = 1
        issue(0, 32'h8000_0004, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 2);
        wait_done(0);
        issue(0, 32'h8000_0003, 1'b0, 3'b100, 32'h0, 32'h0000_00AB, 1'b0, 32'h0000_00AB, 3);
        wait_done(0);
        issue(0, 32'h8000_0002, 1'b0, 3'b010, 32'h0, 32'h1111_1111, 1'b1, 32'h0, 1);
        wait_done(0);
        issue(0, 32'h8000_0000, 1'b1, 3'b100, 32'h55, 32'h0, 1'b1, 32'h0, 1);
        wait_done(0);
        issue(0, 32'h8000_0003, 1'b0, 3'b001, 32'h0, 32'h2222_2222, 1'b1, 32'h0, 1);
        wait_done(0);
        issue(0, 32'h8000_0002, 1'b0, 3'b001, 32'h0, 32'hFFFF_8001, 1'b0, 32'hFFFF_8001, 3);
        wait_done(0);
        issue(0, 32'h8000_0000, 1'b0, 3'b011, 32'h0, 32'h3333_3333, 1'b1, 32'h0, 1);
        wait_done(0);
        issue(0, 32'h8000_0001, 1'b1, 3'b000, 32'hA5A5_A512, 32'h0, 1'b0, 32'h0, 2);
        wait_done(0);
        chk("mem_addr_hold", mem_addr[0], 32'h8000_0001);
        chk("mem_op_hold", 32'(mem_op[0]), 32'(3'b000));

        // Backpressure: response held for 5 cycles, then accepted.
        resp_ready[0] = 1'b0;
        issue(0, 32'h8000_0008, 1'b0, 3'b010, 32'h0, 32'h1122_3344, 1'b0, 32'h1122_3344, 3);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid[0]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("bp_resp_valid");
        repeat (5) @(negedge clk);
        chk("bp_busy", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        resp_ready[0] = 1'b1;
        wait_done(0);
        @(negedge clk);
        chk("bp_back_idle", 32'(busy[0]), 32'd0);
        chk("bp_resp_dropped", 32'(resp_valid[0]), 32'd0);

        // Lane 1: RD_LATENCY = 3
        issue(1, 32'h8000_0010, 1'b0, 3'b010, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 5);
        wait_done(1);
        issue(1, 32'h8000_0012, 1'b0, 3'b101, 32'h0, 32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 5);
        wait_done(1);

        // Reset while the load sits in RD_WAIT.
        issue(1, 32'h8000_0014, 1'b0, 3'b010, 32'h0, 32'h7777_7777, 1'b0, 32'h7777_7777, 5);
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy[1]), 32'd0);
        chk("async_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        chk("async_rst_rd_stb", 32'(mem_rd_stb[1]), 32'd0);
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        issue(1, 32'h8000_0020, 1'b1, 3'b001, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 2);
        wait_done(1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
